// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
package seq_restoring_divider_pkg;

  // Default operand/result width.
  localparam int DIV_WIDTH = 4;

  // Divider control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } div_state_t;

  // Width of an iteration counter that must reach w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/seq_restoring_divider_addsub.sv
// N-bit ripple-carry adder/subtractor: k=0 -> a+b, k=1 -> a-b.
module nbit_addsub #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         k,
  output logic [N-1:0] sum,
  output logic         overflow
);

  logic [N-1:0] b_x;
  logic [N:0]   c;

  // Full-adder chain; subtract by inverting b and injecting carry-in 1.
  always_comb begin
    b_x  = b ^ {N{k}};
    c    = '0;
    c[0] = k;
    sum  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum[i]   = a[i] ^ b_x[i] ^ c[i];
      c[i + 1] = (a[i] & b_x[i]) | (c[i] & (a[i] ^ b_x[i]));
    end
    overflow = c[N] ^ c[N-1];
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider with start/done handshake.
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // R is kept WIDTH bits wide: its top bit is always zero between iterations
  // (R < divisor), so only the shifted value needs the extra bit.
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             zdiv_q, zdiv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  // Trial subtraction on the shared adder-subtractor, subtract mode.
  assign r_sh = {r_q, q_q[WIDTH-1]};

  nbit_addsub #(
    .N (WIDTH + 1)
  ) u_addsub (
    .a        (r_sh),
    .b        ({1'b0, dvs_q}),
    .k        (1'b1),
    .sum      (t),
    .overflow ()
  );

  // Non-negative trial result is kept and sets the quotient bit; else restore.
  always_comb begin
    r_next = t[WIDTH] ? r_sh[WIDTH-1:0] : t[WIDTH-1:0];
    q_next = {q_q[WIDTH-2:0], ~t[WIDTH]};
  end

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    zdiv_d  = zdiv_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dvs_d   = divisor;
          q_d     = dividend;
          r_d     = '0;
          cnt_d   = '0;
          zdiv_d  = (divisor == '0);
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // A zero divisor spends a single RUN cycle so done lands one cycle
        // after acceptance, then reports all-ones and the original dividend.
        if (zdiv_q) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
          quo_d   = '1;
          rem_d   = q_q;
          dbz_d   = 1'b1;
        end else begin
          r_d   = r_next;
          q_d   = q_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
            quo_d   = q_next;
            rem_d   = r_next;
            dbz_d   = 1'b0;
          end
        end
      end
      ST_FIN: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      zdiv_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      zdiv_q  <= zdiv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=4).
module tb_seq_restoring_divider;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_pass   = 0;

  seq_restoring_divider #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: cycles left in the current operation plus the result
  // that becomes visible in its final (done) cycle.
  int       m_cyc = 0;
  bit       armed = 0;
  int       p_q, p_r, p_z;
  int       e_q = 0, e_r = 0, e_z = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_cyc = 0;
      e_q = 0; e_r = 0; e_z = 0;
      armed = 1;
    end else if (m_cyc > 0) begin
      m_cyc--;
      if (m_cyc == 1) begin
        e_q = p_q; e_r = p_r; e_z = p_z;
      end
    end else if (start) begin
      if (divisor == 0) begin
        p_q = (1 << W) - 1; p_r = int'(dividend); p_z = 1;
        m_cyc = 2;
      end else begin
        p_q = int'(dividend) / int'(divisor);
        p_r = int'(dividend) % int'(divisor);
        p_z = 0;
        m_cyc = W + 1;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (armed) begin
      chk("busy",        busy,        (m_cyc > 0) ? 1 : 0);
      chk("done",        done,        (m_cyc == 1) ? 1 : 0);
      chk("quotient",    quotient,    e_q);
      chk("remainder",   remainder,   e_r);
      chk("div_by_zero", div_by_zero, e_z);
    end
  end

  // Issue one start pulse; return the cycle index (1 = cycle after accept)
  // where done was seen, 20 if it never came. Returns at negedge of done cycle.
  task automatic run_div(input int a, input int b, output int lat);
    @(negedge clk);
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int npulse;
    int dcyc;
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_quo",  quotient, 0);
    chk("reset_rem",  remainder, 0);
    chk("reset_dbz",  div_by_zero, 0);

    // 13/4
    run_div(13, 4, lat);
    chk("t1_latency", lat, 5);
    chk("t1_quo", quotient, 3);
    chk("t1_rem", remainder, 1);
    chk("t1_dbz", div_by_zero, 0);

    // 15/1, 7/9, 0/5
    run_div(15, 1, lat);
    chk("t2a_quo", quotient, 15);
    chk("t2a_rem", remainder, 0);
    run_div(7, 9, lat);
    chk("t2b_quo", quotient, 0);
    chk("t2b_rem", remainder, 7);
    run_div(0, 5, lat);
    chk("t2c_quo", quotient, 0);
    chk("t2c_rem", remainder, 0);

    // 9/0
    run_div(9, 0, lat);
    chk("t3_latency", lat, 2);
    chk("t3_quo", quotient, 15);
    chk("t3_rem", remainder, 9);
    chk("t3_dbz", div_by_zero, 1);

    // 12/5 with a 15/3 start pulse while busy
    @(negedge clk);
    dividend = 4'd12; divisor = 4'd5; start = 1'b1;
    npulse = 0; dcyc = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (done) begin
        npulse++;
        dcyc = c;
      end
      start    = (c == 2 || c == 3);
      dividend = (c >= 2) ? 4'd15 : 4'd12;
      divisor  = (c >= 2) ? 4'd3  : 4'd5;
    end
    start = 1'b0;
    chk("t4_pulses", npulse, 1);
    chk("t4_done_cycle", dcyc, 5);
    chk("t4_quo", quotient, 2);
    chk("t4_rem", remainder, 2);

    // 14/3 aborted by reset (with start also high during reset)
    @(negedge clk);
    dividend = 4'd14; divisor = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_quo", quotient, 0);
    chk("t5_rem", remainder, 0);
    chk("t5_dbz", div_by_zero, 0);
    run_div(14, 3, lat);
    chk("t5_latency", lat, 5);
    chk("t5_quo2", quotient, 4);
    chk("t5_rem2", remainder, 2);

    // Exhaustive back-to-back
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_div(a, b, lat);
        chk("exh_latency", lat, (b == 0) ? 2 : W + 1);
      end
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
